// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types and constants for the multiply/divide unit.
package muldiv_unit_pkg;
  typedef logic        u1;
  typedef logic [4:0]  u5;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  typedef enum logic [1:0] {MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3} muldiv_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} muldiv_state_t;
  localparam int MULDIV_ITER = 32;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate, per half or across the whole 2W value.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] x_i,
  input  logic           wide_i,
  input  logic           neg_hi_i,
  input  logic           neg_lo_i,
  output logic [2*W-1:0] y_o
);
  logic [W-1:0] hi_x, lo_x;
  assign hi_x = x_i[2*W-1:W];
  assign lo_x = x_i[W-1:0];
  assign y_o  = wide_i ? (neg_lo_i ? -x_i : x_i)
                       : {neg_hi_i ? -hi_x : hi_x, neg_lo_i ? -lo_x : lo_x};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(ITER);
  muldiv_state_t  state_q;
  logic [CW-1:0]  cnt_q;
  u1              sgn_q, sa_q, sb_q, bz_q, done_q, ge;
  logic [W-1:0]   a_q, m_q, rem_q, hi_q, lo_q, rem_d, quo_d;
  logic [2*W-1:0] acc_q, acc_d, ops, res;
  logic [W:0]     mul_sum, div_sh;
  muldiv_sign_fix #(.W(W)) u_abs (
    .x_i     ({a, b}),
    .wide_i  (1'b0),
    .neg_hi_i(~op[0] & a[W-1]),
    .neg_lo_i(~op[0] & b[W-1]),
    .y_o     (ops)
  );
  // m_q is the multiplicand in MUL and the divisor in DIV; acc_q low half holds multiplier or dividend/quotient
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_sh  = {rem_q, acc_q[W-1]};
    ge      = div_sh >= {1'b0, m_q};
    rem_d   = ge ? div_sh[W-1:0] - m_q : div_sh[W-1:0];
    quo_d   = {acc_q[W-2:0], ge};
    acc_d   = state_q == ST_MUL ? {mul_sum, acc_q[W-1:1]} : {acc_q[2*W-1:W], quo_d};
  end
  muldiv_sign_fix #(.W(W)) u_fix (
    .x_i     (state_q == ST_MUL ? acc_d : {rem_d, quo_d}),
    .wide_i  (state_q == ST_MUL),
    .neg_hi_i(sgn_q & sa_q),
    .neg_lo_i(sgn_q & (sa_q ^ sb_q)),
    .y_o     (res)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      m_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (hi_we) hi_q <= wd;
        if (lo_we) lo_q <= wd;
        if (start) begin
          state_q <= op[1] ? ST_DIV : ST_MUL;
          cnt_q   <= '0;
          sgn_q   <= ~op[0];
          sa_q    <= a[W-1];
          sb_q    <= b[W-1];
          bz_q    <= b == '0;
          a_q     <= a;
          m_q     <= op[1] ? ops[W-1:0] : ops[2*W-1:W];
          acc_q   <= {{W{1'b0}}, op[1] ? ops[2*W-1:W] : ops[W-1:0]};
          rem_q   <= '0;
        end
      end else begin
        acc_q <= acc_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          hi_q    <= (state_q == ST_DIV && bz_q) ? a_q : res[2*W-1:W];
          lo_q    <= (state_q == ST_DIV && bz_q) ? '1  : res[W-1:0];
        end
      end
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
